// File: rtl/tt_pad_pkg.sv
// Shared types and helpers for the tile pad-sharing arbiter.
package tt_pad_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN  = 2'd1,
    TURN = 2'd2
  } state_e;

  localparam logic PAD_SAFE_PD = 1'b1;
  localparam logic PAD_SAFE_PU = 1'b0;

  typedef struct packed {
    logic a;
    logic oe;
    logic ie;
    logic sl;
    logic cs;
    logic pd;
    logic pu;
  } pad_ctrl_t;

  function automatic pad_ctrl_t pad_safe();
    pad_ctrl_t p;
    p    = '0;
    p.pd = PAD_SAFE_PD;
    p.pu = PAD_SAFE_PU;
    return p;
  endfunction

  // Owner view of the pad: output value is masked when not driving, pull-down beats pull-up.
  function automatic pad_ctrl_t pad_own(input logic a, input logic oe,
                                        input logic pu, input logic pd);
    pad_ctrl_t p;
    p    = '0;
    p.a  = a & oe;
    p.oe = oe;
    p.ie = ~oe;
    p.pd = pd;
    p.pu = pu & ~pd;
    return p;
  endfunction

endpackage

// File: rtl/tt_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module tt_rr_pick #(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  onehot,
  output logic [PW-1:0] idx,
  output logic          any
);

  int w_sel;

  // Scan offsets from farthest to nearest so the nearest match is the one that sticks.
  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = |req;
    w_sel  = 0;
    for (int off = N - 1; off >= 0; off--) begin
      w_sel = (int'(ptr) + off) % N;
      if (req[w_sel]) begin
        onehot        = '0;
        onehot[w_sel] = 1'b1;
        idx           = PW'(w_sel);
      end
    end
  end

endmodule

// File: rtl/tt_pad_share_arb.sv
// Round-robin owner of one bidirectional tile pad with bounded tenure and an undriven
// turnaround gap between owners; all pad controls and grants are registered.
module tt_pad_share_arb
  import tt_pad_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int TURN_CYCLES = 2,
  parameter int MAX_HOLD    = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] req_a,
  input  logic [N_REQ-1:0] req_oe,
  input  logic [N_REQ-1:0] req_pu,
  input  logic [N_REQ-1:0] req_pd,
  output logic [N_REQ-1:0] gnt,
  output logic             busy,
  output logic             rd_y,
  input  logic             pad_y,
  output logic             pad_a,
  output logic             pad_oe,
  output logic             pad_ie,
  output logic             pad_sl,
  output logic             pad_cs,
  output logic             pad_pd,
  output logic             pad_pu
);

  localparam int PW = $clog2(N_REQ);
  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam int TW = $clog2(TURN_CYCLES + 1);

  state_e           r_state;
  logic [N_REQ-1:0] r_gnt;
  logic             r_busy;
  logic [PW-1:0]    r_ptr;
  logic [PW-1:0]    r_owner;
  logic [HW-1:0]    r_hold;
  logic [TW-1:0]    r_turn;
  pad_ctrl_t        r_pad;
  logic [1:0]       r_sync;

  logic [N_REQ-1:0] w_pick_onehot;
  logic [PW-1:0]    w_pick_idx;
  logic             w_pick_any;
  logic             w_hold_max;
  logic             w_release;
  logic [PW-1:0]    w_ptr_inc;
  pad_ctrl_t        w_pick_pad;
  pad_ctrl_t        w_owner_pad;

  tt_rr_pick #(.N(N_REQ), .PW(PW)) u_pick (
    .req    (req),
    .ptr    (r_ptr),
    .onehot (w_pick_onehot),
    .idx    (w_pick_idx),
    .any    (w_pick_any)
  );

  assign w_pick_pad  = pad_own(req_a[w_pick_idx], req_oe[w_pick_idx],
                               req_pu[w_pick_idx], req_pd[w_pick_idx]);
  assign w_owner_pad = pad_own(req_a[r_owner], req_oe[r_owner],
                               req_pu[r_owner], req_pd[r_owner]);
  assign w_hold_max  = (r_hold == HW'(MAX_HOLD));
  // Tenure limit only bites when somebody else is actually waiting.
  assign w_release   = !req[r_owner] || (w_hold_max && (|(req & ~r_gnt)));
  assign w_ptr_inc   = (r_owner == PW'(N_REQ - 1)) ? '0 : r_owner + PW'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_gnt   <= '0;
      r_busy  <= 1'b0;
      r_ptr   <= '0;
      r_owner <= '0;
      r_hold  <= '0;
      r_turn  <= '0;
      r_pad   <= pad_safe();
    end else begin
      case (r_state)
        IDLE: begin
          if (w_pick_any) begin
            r_state <= OWN;
            r_gnt   <= w_pick_onehot;
            r_owner <= w_pick_idx;
            r_hold  <= '0;
            r_busy  <= 1'b1;
            r_pad   <= w_pick_pad;
          end
        end
        OWN: begin
          if (w_release) begin
            r_state <= TURN;
            r_gnt   <= '0;
            r_ptr   <= w_ptr_inc;
            r_turn  <= '0;
            r_pad   <= pad_safe();
          end else begin
            r_pad <= w_owner_pad;
            if (!w_hold_max) r_hold <= r_hold + HW'(1);
          end
        end
        TURN: begin
          if (r_turn == TW'(TURN_CYCLES - 1)) begin
            if (w_pick_any) begin
              r_state <= OWN;
              r_gnt   <= w_pick_onehot;
              r_owner <= w_pick_idx;
              r_hold  <= '0;
              r_pad   <= w_pick_pad;
            end else begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end
          end else begin
            r_turn <= r_turn + TW'(1);
          end
        end
        default: begin
          r_state <= IDLE;
          r_gnt   <= '0;
          r_busy  <= 1'b0;
          r_pad   <= pad_safe();
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_sync <= 2'b00;
    else     r_sync <= {r_sync[0], pad_y};
  end

  assign gnt    = r_gnt;
  assign busy   = r_busy;
  assign rd_y   = r_sync[1];
  assign pad_a  = r_pad.a;
  assign pad_oe = r_pad.oe;
  assign pad_ie = r_pad.ie;
  assign pad_sl = r_pad.sl;
  assign pad_cs = r_pad.cs;
  assign pad_pd = r_pad.pd;
  assign pad_pu = r_pad.pu;

endmodule
